// File: rtl/bus_timer.sv
// Memory-mapped prescaled 32-bit timer with match flag, level IRQ and one-shot mode.
// Optional compare/PWM channel at offset 0x14 is built when BUS_TIMER_PWM_EN is defined.
module bus_timer #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sel,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wData,
    output logic [DATA_W-1:0] rData,
    output logic              irq,
    output logic              pwm_o
);

    localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(5'h00);
    localparam logic [ADDR_W-1:0] A_PSC    = ADDR_W'(5'h04);
    localparam logic [ADDR_W-1:0] A_ARR    = ADDR_W'(5'h08);
    localparam logic [ADDR_W-1:0] A_CNT    = ADDR_W'(5'h0C);
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(5'h10);
    localparam logic [ADDR_W-1:0] A_CMP    = ADDR_W'(5'h14);
    localparam logic [DATA_W-1:0] ZERO     = {DATA_W{1'b0}};
    localparam logic [DATA_W-1:0] ONE      = {{(DATA_W-1){1'b0}}, 1'b1};

    logic [2:0]        ctrl_q, ctrl_d;
    logic [DATA_W-1:0] psc_q, psc_d;
    logic [DATA_W-1:0] arr_q, arr_d;
    logic [DATA_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] psc_cnt_q, psc_cnt_d;
    logic              mf_q, mf_d;
    logic              irq_q, irq_d;
    logic              pwm_q, pwm_d;
    logic [DATA_W-1:0] cmp_rd_s;
    logic              wr_s, tick_s, match_s;

    assign wr_s    = sel & we;
    assign tick_s  = ctrl_q[0] & (psc_cnt_q == psc_q);
    assign match_s = tick_s & (cnt_q == arr_q);

`ifdef BUS_TIMER_PWM_EN
    logic [DATA_W-1:0] cmp_q, cmp_d;

    // Compare register and PWM level; CMP=0 never drives high, CMP>ARR stays high while running.
    always_comb begin
        cmp_d = cmp_q;
        if (wr_s && (addr == A_CMP)) begin
            cmp_d = wData;
        end else begin
            cmp_d = cmp_q;
        end
        pwm_d    = ctrl_q[0] & (cnt_q < cmp_q);
        cmp_rd_s = cmp_q;
    end

    // Compare register storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmp_q <= ZERO;
        end else begin
            cmp_q <= cmp_d;
        end
    end
`else
    // Without the compare channel the PWM level is constant low and 0x14 reads as zero.
    always_comb begin
        pwm_d    = 1'b0;
        cmp_rd_s = ZERO;
    end
`endif

    // Next-state for control, prescaler, counter and flag; bus writes take priority over ticks.
    always_comb begin
        ctrl_d    = ctrl_q;
        psc_d     = psc_q;
        arr_d     = arr_q;
        cnt_d     = cnt_q;
        psc_cnt_d = psc_cnt_q;
        mf_d      = mf_q;

        if (ctrl_q[0]) begin
            psc_cnt_d = tick_s ? ZERO : (psc_cnt_q + ONE);
        end else begin
            psc_cnt_d = psc_cnt_q;
        end

        if (match_s) begin
            cnt_d = ZERO;
            mf_d  = 1'b1;
            if (!ctrl_q[1]) begin
                ctrl_d[0] = 1'b0;
            end else begin
                ctrl_d[0] = ctrl_q[0];
            end
        end else if (tick_s) begin
            cnt_d = cnt_q + ONE;
        end else begin
            cnt_d = cnt_q;
        end

        if (wr_s) begin
            case (addr)
                A_CTRL: begin
                    ctrl_d = wData[2:0];
                    if (wData[0] && !ctrl_q[0]) begin
                        psc_cnt_d = ZERO;
                    end else begin
                        psc_cnt_d = psc_cnt_d;
                    end
                end
                A_PSC: begin
                    psc_d     = wData;
                    psc_cnt_d = ZERO;
                end
                A_ARR:    arr_d = wData;
                A_CNT:    cnt_d = wData;
                A_STATUS: begin
                    // A simultaneous match keeps the flag set.
                    if (wData[0] && !match_s) begin
                        mf_d = 1'b0;
                    end else begin
                        mf_d = mf_d;
                    end
                end
                default: ctrl_d = ctrl_d;
            endcase
        end else begin
            ctrl_d = ctrl_d;
        end

        irq_d = mf_q & ctrl_q[2];
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q    <= 3'b000;
            psc_q     <= ZERO;
            arr_q     <= ZERO;
            cnt_q     <= ZERO;
            psc_cnt_q <= ZERO;
            mf_q      <= 1'b0;
            irq_q     <= 1'b0;
            pwm_q     <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            psc_q     <= psc_d;
            arr_q     <= arr_d;
            cnt_q     <= cnt_d;
            psc_cnt_q <= psc_cnt_d;
            mf_q      <= mf_d;
            irq_q     <= irq_d;
            pwm_q     <= pwm_d;
        end
    end

    // Combinational read mux; idle or write cycles return zero.
    always_comb begin
        rData = ZERO;
        if (sel && !we) begin
            case (addr)
                A_CTRL:   rData = {{(DATA_W-3){1'b0}}, ctrl_q};
                A_PSC:    rData = psc_q;
                A_ARR:    rData = arr_q;
                A_CNT:    rData = cnt_q;
                A_STATUS: rData = {{(DATA_W-1){1'b0}}, mf_q};
                A_CMP:    rData = cmp_rd_s;
                default:  rData = ZERO;
            endcase
        end else begin
            rData = ZERO;
        end
    end

    assign irq   = irq_q;
    assign pwm_o = pwm_q;

endmodule

// File: tb/tb_bus_timer.sv
// Directed bench for bus_timer: register reset, periodic and one-shot counting, flag clearing,
// counter wrap, asynchronous reset and the compare/PWM channel (BUS_TIMER_PWM_EN).
module tb_bus_timer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sel = 1'b0;
    logic        we = 1'b0;
    logic [4:0]  addr = 5'h00;
    logic [31:0] wData = 32'h0;
    logic [31:0] rData;
    logic        irq;
    logic        pwm_o;

    int errors = 0;
    int checks = 0;

    bus_timer #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .sel(sel), .we(we), .addr(addr),
        .wData(wData), .rData(rData), .irq(irq), .pwm_o(pwm_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        sel = 1'b1; we = 1'b1; addr = a; wData = d;
        @(posedge clk);
        #1;
        sel = 1'b0; we = 1'b0; wData = 32'h0;
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
        sel = 1'b1; we = 1'b0; addr = a;
        #1;
        check(tag, rData, exp);
        sel = 1'b0;
        #1;
    endtask

    initial begin
        int highs;
        // Reset state
        step(3);
        for (int i = 0; i < 6; i++) begin
            rd_chk($sformatf("reset_reg%0d", i), 5'(i * 4), 32'h0);
        end
        check("reset_irq", {31'h0, irq}, 32'h0);
        check("reset_pwm", {31'h0, pwm_o}, 32'h0);
        reset = 1'b1;
        step(1);

        // Periodic: PSC=3, ARR=4, EN|AR|IE
        wr(5'h04, 32'd3);
        wr(5'h08, 32'd4);
        wr(5'h00, 32'h7);
        rd_chk("per_cnt0", 5'h0C, 32'd0);
        step(4);
        rd_chk("per_cnt1", 5'h0C, 32'd1);
        step(12);
        rd_chk("per_cnt4", 5'h0C, 32'd4);
        rd_chk("per_mf_pre", 5'h10, 32'd0);
        step(4);
        rd_chk("per_wrap0", 5'h0C, 32'd0);
        rd_chk("per_mf_set", 5'h10, 32'd1);
        check("per_irq_lag", {31'h0, irq}, 32'h0);
        step(1);
        check("per_irq_set", {31'h0, irq}, 32'h1);
        // Clear on a non-match cycle
        wr(5'h10, 32'h1);
        rd_chk("clr_mf", 5'h10, 32'd0);
        step(1);
        check("clr_irq", {31'h0, irq}, 32'h0);
        // Clear on the next match edge loses to the set
        step(16);
        wr(5'h10, 32'h1);
        rd_chk("clr_race_mf", 5'h10, 32'd1);
        rd_chk("clr_race_cnt", 5'h0C, 32'd0);
        rd_chk("per_still_en", 5'h00, 32'h7);
        wr(5'h00, 32'h0);
        wr(5'h10, 32'h1);

        // One-shot: PSC=0, ARR=2, EN|IE
        wr(5'h04, 32'd0);
        wr(5'h08, 32'd2);
        wr(5'h00, 32'h5);
        rd_chk("os_cnt0", 5'h0C, 32'd0);
        step(1);
        rd_chk("os_cnt1", 5'h0C, 32'd1);
        step(1);
        rd_chk("os_cnt2", 5'h0C, 32'd2);
        step(1);
        rd_chk("os_cnt_end", 5'h0C, 32'd0);
        rd_chk("os_ctrl", 5'h00, 32'h4);
        rd_chk("os_mf", 5'h10, 32'd1);
        step(2);
        rd_chk("os_hold", 5'h0C, 32'd0);
        check("os_irq", {31'h0, irq}, 32'h1);
        wr(5'h00, 32'h0);
        wr(5'h10, 32'h1);

        // Wrap past 2^32-1 with CNT above ARR
        wr(5'h0C, 32'hFFFF_FFFE);
        wr(5'h08, 32'd3);
        wr(5'h00, 32'h1);
        step(1);
        rd_chk("wrap_ffff", 5'h0C, 32'hFFFF_FFFF);
        step(1);
        rd_chk("wrap_zero", 5'h0C, 32'd0);
        rd_chk("wrap_no_mf", 5'h10, 32'd0);
        step(3);
        rd_chk("wrap_cnt3", 5'h0C, 32'd3);
        rd_chk("wrap_mf_pre", 5'h10, 32'd0);
        step(1);
        rd_chk("wrap_back0", 5'h0C, 32'd0);
        rd_chk("wrap_mf", 5'h10, 32'd1);
        step(2);

        // Asynchronous reset mid-count
        reset = 1'b0;
        #1;
        rd_chk("arst_cnt", 5'h0C, 32'd0);
        rd_chk("arst_ctrl", 5'h00, 32'h0);
        rd_chk("arst_arr", 5'h08, 32'h0);
        rd_chk("arst_mf", 5'h10, 32'h0);
        reset = 1'b1;
        step(1);

`ifdef BUS_TIMER_PWM_EN
        wr(5'h08, 32'd9);
        wr(5'h14, 32'd3);
        rd_chk("cmp_rd", 5'h14, 32'd3);
        wr(5'h00, 32'h3);
        step(5);
        highs = 0;
        for (int i = 0; i < 20; i++) begin
            if (pwm_o) highs++;
            step(1);
        end
        check("pwm_duty", 32'(highs), 32'd6);
        wr(5'h00, 32'h0);
        step(1);
        check("pwm_off", {31'h0, pwm_o}, 32'h0);
`else
        wr(5'h14, 32'd5);
        rd_chk("cmp_absent", 5'h14, 32'd0);
        wr(5'h08, 32'd9);
        wr(5'h00, 32'h3);
        highs = 0;
        for (int i = 0; i < 20; i++) begin
            if (pwm_o) highs++;
            step(1);
        end
        check("pwm_tied", 32'(highs), 32'd0);
        rd_chk("nopwm_running", 5'h00, 32'h3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
